// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants, rounding modes and the i2f state encoding
package fpu_pkg;
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RDN = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RTZ = 2'b11;
  localparam int BIAS = 127;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} i2f_state_t;
endpackage

// File: rtl/fp_round.sv
// fp_round: rounds a normalized 32-bit magnitude (hidden bit dropped) to single precision
module fp_round
  import fpu_pkg::*;
(
  input  logic             sign,
  input  logic [EXP_W-1:0] exp,
  input  logic [30:0]      mag,
  input  logic [1:0]       rm,
  output logic [31:0]      d,
  output logic             inexact
);
  logic [FRAC_W-1:0] frac;
  logic              g;
  logic              st;
  logic              inc;
  logic [FRAC_W:0]   sum;
  // guard/sticky extraction, mode-dependent increment, carry folds into the exponent
  always_comb begin
    frac = mag[30:8];
    g = mag[7];
    st = |mag[6:0];
    inexact = g | st;
    inc = rm == RM_RNE ? g & (st | frac[0]) :
          rm == RM_RDN ? sign & inexact :
          rm == RM_RUP ? ~sign & inexact : 1'b0;
    sum = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
    d = {sign, exp + {{(EXP_W-1){1'b0}}, sum[FRAC_W]}, sum[FRAC_W-1:0]};
  end
endmodule

// File: rtl/i2f_iter.sv
// i2f_iter: iterative 32-bit integer to single-precision float converter with valid/ready handshakes
module i2f_iter
  import fpu_pkg::*;
#(
  parameter logic SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [1:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        p_lost
);
  i2f_state_t       state;
  logic             sign;
  logic [31:0]      mag;
  logic [EXP_W-1:0] exp;
  logic [1:0]       rm_q;
  logic [2:0]       step;
  logic [4:0]       sh;
  logic [31:0]      mask;
  logic [31:0]      rd;
  logic             rinexact;
  assign sh = 5'd16 >> step;
  assign mask = ~(32'hFFFF_FFFF >> sh);
  fp_round u_round (
    .sign    (sign),
    .exp     (exp),
    .mag     (mag[30:0]),
    .rm      (rm_q),
    .d       (rd),
    .inexact (rinexact)
  );
  // control FSM: accept, 5 binary-search normalize steps, round, hold until consumed
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      d <= '0;
      p_lost <= 1'b0;
      sign <= 1'b0;
      mag <= '0;
      exp <= '0;
      rm_q <= '0;
      step <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= SIGNED & a[31];
          mag <= (SIGNED & a[31]) ? ~a + 32'd1 : a;
          exp <= EXP_W'(BIAS + 31);
          rm_q <= rm;
          step <= '0;
          in_ready <= 1'b0;
          state <= NORM;
        end
        NORM: begin
          if ((mag & mask) == '0) begin
            mag <= mag << sh;
            exp <= exp - {3'b000, sh};
          end
          step <= step + 3'd1;
          if (step == 3'd4) state <= ROUND;
        end
        ROUND: begin
          d <= mag == '0 ? '0 : rd;
          p_lost <= mag != '0 & rinexact;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2f_iter.sv
// tb_i2f_iter: directed self-checking bench for signed and unsigned i2f_iter instances
module tb_i2f_iter;
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        in_valid_s = 1'b0, in_valid_u = 1'b0;
  logic        in_ready_s, in_ready_u;
  logic [31:0] a = '0;
  logic [1:0]  rm = '0;
  logic        out_valid_s, out_valid_u;
  logic        out_ready = 1'b0;
  logic [31:0] d_s, d_u;
  logic        p_lost_s, p_lost_u;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  i2f_iter #(.SIGNED(1'b1)) u_s (
    .clk(clk), .clrn(clrn), .in_valid(in_valid_s), .in_ready(in_ready_s), .a(a), .rm(rm),
    .out_valid(out_valid_s), .out_ready(out_ready), .d(d_s), .p_lost(p_lost_s)
  );
  i2f_iter #(.SIGNED(1'b0)) u_u (
    .clk(clk), .clrn(clrn), .in_valid(in_valid_u), .in_ready(in_ready_u), .a(a), .rm(rm),
    .out_valid(out_valid_u), .out_ready(out_ready), .d(d_u), .p_lost(p_lost_u)
  );

  task automatic run(input bit uns, input logic [31:0] av, input logic [1:0] rmv,
                     output logic [31:0] dv, output logic pv, output int lat);
    @(negedge clk);
    a = av;
    rm = rmv;
    if (uns) in_valid_u = 1'b1; else in_valid_s = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s = 1'b0;
    in_valid_u = 1'b0;
    a = 32'hDEAD_BEEF;
    rm = ~rmv;
    lat = 0;
    while (!(uns ? out_valid_u : out_valid_s) && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    dv = uns ? d_u : d_s;
    pv = uns ? p_lost_u : p_lost_s;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready_s !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_s); end
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_s); end
    checks++; if (d_s !== 32'h0) begin errors++; $display("FAIL reset_d got=%h exp=00000000", d_s); end
    checks++; if (p_lost_s !== 1'b0) begin errors++; $display("FAIL reset_p_lost got=%b exp=0", p_lost_s); end
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_signed();
    logic [31:0] va [12] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000,
                            32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                            32'h0100_0001, 32'h0100_0003, 32'h8000_0001, 32'h8000_0001};
    logic [1:0]  vr [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10,
                            2'b00, 2'b00, 2'b01, 2'b10};
    logic [31:0] vd [12] = '{32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h0000_0000,
                            32'h4F00_0000, 32'h4EFF_FFFF, 32'h4EFF_FFFF, 32'h4F00_0000,
                            32'h4B80_0000, 32'h4B80_0002, 32'hCF00_0000, 32'hCEFF_FFFF};
    logic        vp [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] dv;
    logic        pv;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      run(1'b0, va[i], vr[i], dv, pv, lat);
      checks++; if (dv !== vd[i]) begin errors++; $display("FAIL signed_d a=%h rm=%b got=%h exp=%h", va[i], vr[i], dv, vd[i]); end
      checks++; if (pv !== vp[i]) begin errors++; $display("FAIL signed_p_lost a=%h rm=%b got=%b exp=%b", va[i], vr[i], pv, vp[i]); end
      checks++; if (lat != 6) begin errors++; $display("FAIL signed_latency a=%h got=%0d exp=6", va[i], lat); end
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [1:0]  vr [3] = '{2'b00, 2'b11, 2'b01};
    logic [31:0] vd [3] = '{32'h4F80_0000, 32'h4F7F_FFFF, 32'h4F00_0000};
    logic        vp [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] dv;
    logic        pv;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run(1'b1, va[i], vr[i], dv, pv, lat);
      checks++; if (dv !== vd[i]) begin errors++; $display("FAIL unsigned_d a=%h rm=%b got=%h exp=%h", va[i], vr[i], dv, vd[i]); end
      checks++; if (pv !== vp[i]) begin errors++; $display("FAIL unsigned_p_lost a=%h got=%b exp=%b", va[i], pv, vp[i]); end
      checks++; if (lat != 6) begin errors++; $display("FAIL unsigned_latency a=%h got=%0d exp=6", va[i], lat); end
    end
  endtask

  task automatic test_hold();
    int lat = 0;
    @(negedge clk);
    a = 32'h0000_0005;
    rm = 2'b00;
    in_valid_s = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s = 1'b0;
    while (!out_valid_s && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL hold_latency got=%0d exp=6", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_s !== 1'b1 || d_s !== 32'h40A0_0000 || in_ready_s !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cycle=%0d got v=%b d=%h rdy=%b exp v=1 d=40a00000 rdy=0", i, out_valid_s, d_s, in_ready_s);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin errors++; $display("FAIL hold_release got v=%b rdy=%b exp v=0 rdy=1", out_valid_s, in_ready_s); end
    checks++; if (d_s !== 32'h40A0_0000) begin errors++; $display("FAIL hold_d_kept got=%h exp=40a00000", d_s); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int acc [$];
    int waitc = 0;
    @(negedge clk);
    a = 32'h0000_0003;
    rm = 2'b00;
    in_valid_s = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready_s) acc.push_back(cyc);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid_s = 1'b0;
    while (!in_ready_s && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    out_ready = 1'b0;
    checks++; if (acc.size() < 4) begin errors++; $display("FAIL b2b_accepts got=%0d exp>=4", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++; if (acc[i] - acc[i-1] != 8) begin errors++; $display("FAIL b2b_gap idx=%0d got=%0d exp=8", i, acc[i] - acc[i-1]); end
    end
    checks++; if (d_s !== 32'h4040_0000) begin errors++; $display("FAIL b2b_d got=%h exp=40400000", d_s); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    a = 32'h0000_0007;
    rm = 2'b00;
    in_valid_s = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    checks++; if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0) begin errors++; $display("FAIL midreset_hs got rdy=%b v=%b exp rdy=1 v=0", in_ready_s, out_valid_s); end
    checks++; if (d_s !== 32'h0 || p_lost_s !== 1'b0) begin errors++; $display("FAIL midreset_out got d=%h p=%b exp d=00000000 p=0", d_s, p_lost_s); end
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid_s) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_result got out_valid=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2f_iter.md
Name: i2f_iter

Overview:
- Multi-cycle converter from 32-bit integer to IEEE-754 single-precision float; it is the reverse-direction companion of the FPU's float-to-integer unit.
- Uses an iterative 5-step normalizer, then one rounding cycle under a selectable rounding mode.
- Valid/ready handshakes on both input and output so it sits on the FPU issue/writeback path.
- Reports inexact conversion via p_lost.

Parameters:
- SIGNED, 1, 1 = input is two's complement; 0 = input is unsigned magnitude.

Ports:
- clk  input  1  clock, rising edge
- clrn  input  1  asynchronous active-low reset
- in_valid  input  1  operand a and rm are valid
- in_ready  output  1  converter can accept an operand
- a  input  32  integer operand
- rm  input  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero
- out_valid  output  1  d/p_lost are valid
- out_ready  input  1  consumer accepts result
- d  output  32  float result {sign, exp[7:0], frac[22:0]}
- p_lost  output  1  precision lost (result inexact)

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE; in_ready=1, out_valid=0, d=0, p_lost=0; all internal registers cleared. Reset mid-conversion discards the operation, and no result is produced.
- States: IDLE, NORM, ROUND, DONE. in_ready=1 only in IDLE.
- IDLE -> NORM on in_valid&in_ready. Registered at that edge:
  - sign = SIGNED & a[31].
  - mag = sign ? -a : a, as a 32-bit unsigned value; 0x80000000 yields mag 0x80000000.
  - exp = 158 (127+31); rm; step=0.
- NORM runs exactly 5 cycles, one step per edge, with shift amounts s = 16, 8, 4, 2, 1 for step 0..4.
  - Per step: if mag[31:32-s]==0 then mag <<= s and exp -= s.
  - After step 4 the state moves to ROUND; mag[31]=1 unless mag==0.
- ROUND (one edge), combinational from mag:
  - frac = mag[30:8], g = mag[7], st = |mag[6:0], inexact = g|st.
  - Increment condition: rm00 g&(st|frac[0]); rm01 sign&inexact; rm10 ~sign&inexact; rm11 never.
  - frac+1 carry out -> frac=0, exp+1. Maximum result exp is 159, so there is no overflow or infinity case.
  - mag==0 -> d=0x00000000 (+0), p_lost=0.
  - Otherwise d={sign, exp, frac}, p_lost=inexact.
  - Registers d and p_lost, sets out_valid=1, enters DONE.
- Latency: out_valid rises 6 clock edges after the accepting edge, fixed and independent of the operand.
- DONE: d, p_lost and out_valid are held stable while out_ready=0. On out_valid&out_ready: out_valid=0, state=IDLE, in_ready=1 next cycle. d and p_lost keep their last value.
- A new operand cannot be accepted in the same cycle as result hand-off. Throughput is one result per 8 cycles with out_ready held high.
- in_valid outside IDLE is ignored; a and rm are sampled only at the accepting edge.
- No denormal, NaN or infinity results are possible. There is no invalid flag.

Decomposition:
- Shared package fpu_pkg holds:
  - rounding-mode constants RM_RNE=2'b00, RM_RDN=2'b01, RM_RUP=2'b10, RM_RTZ=2'b11
  - BIAS=127, EXP_W=8, FRAC_W=23
  - i2f state enum {IDLE, NORM, ROUND, DONE}
- One combinational sub-module, fp_round, is natural: inputs sign, exp, mag[30:0], rm; outputs packed d and inexact. The same module is reusable by the other FPU converters.

Test Plan:
- SIGNED=1, a=0x00000001, rm=00: d=0x3F800000, p_lost=0, out_valid exactly 6 edges after accept.
- SIGNED=1, a=0xFFFFFFFF: d=0xBF800000. a=0x80000000: d=0xCF000000, p_lost=0. a=0: d=0x00000000, p_lost=0.
- a=0x7FFFFFFF: rm=00 -> 0x4F000000, p_lost=1; rm=11 -> 0x4EFFFFFF, p_lost=1; rm=01 -> 0x4EFFFFFF; rm=10 -> 0x4F000000.
- Tie cases: a=0x01000001 rm=00 -> 0x4B800000, p_lost=1 (ties to even, down); a=0x01000003 rm=00 -> 0x4B800002 (up).
- SIGNED=0, a=0xFFFFFFFF, rm=00: d=0x4F800000, p_lost=1; same with rm=11 -> 0x4F7FFFFF.
- Handshakes:
  - Hold out_ready=0 for 10 cycles: d and out_valid stay stable, and in_ready=0 throughout.
  - Back-to-back operands with out_ready=1: one accept every 8 cycles.
  - clrn pulsed low during NORM: outputs return to reset values immediately, and no out_valid follows.
